edge_counter_bank: RTL and testbench
====================================

Name: edge_counter_bank

Overview:
Multi-channel rising-edge event counter. Successor to the single-channel edge counter.
- Generalised over channel count and width.
- Adds per-channel up/down direction, synchronous clear/load, saturate-or-wrap mode, terminal flags and a sticky wrap flag.
- Sits between event sources (buttons, strobes, peripheral pulses) and the register/display logic that reads the counts.

Parameters:
NUM_CH, 4, number of independent counter channels (>=1)
COUNT_WIDTH, 8, bits per channel counter (>=2)

Ports:
clk_i  in  1  clock; all state updates on rising edge
rstn_i  in  1  asynchronous, active-low reset
next_i  in  NUM_CH  per-channel event input; a 0->1 transition between consecutive samples counts one event
dir_i  in  NUM_CH  per-channel direction: 1=up, 0=down; sampled in the cycle the edge is detected
clr_i  in  NUM_CH  per-channel synchronous clear
load_i  in  NUM_CH  per-channel synchronous load
load_val_i  in  NUM_CH*COUNT_WIDTH  load values; channel c at bits [c*COUNT_WIDTH +: COUNT_WIDTH]
sat_i  in  NUM_CH  per-channel mode: 1=saturate at limits, 0=wrap modulo 2^COUNT_WIDTH
count_o  out  NUM_CH*COUNT_WIDTH  counter values, packed like load_val_i
max_o  out  NUM_CH  channel count equals all-ones
zero_o  out  NUM_CH  channel count equals zero
wrap_o  out  NUM_CH  sticky: channel has wrapped (up past max or down past 0) since the last clear/reset

Behaviour:
- Reset (async assert, sync to clk_i on release):
  - count=0, edge-history register=0, wrap_o=0.
  - Hence zero_o=all ones, max_o=0.
- Edge detect, per channel:
  - edge = next_i & ~hist; hist <= next_i every cycle.
  - next_i already high at the first clock after reset release counts as one edge.
  - A level held high counts once. No glitch filtering.
- Latency: edge sampled at clock edge N -> count_o updated after edge N (visible in cycle N+1). Flags are combinational from the count register, so they carry the same latency.
- Priority per channel, same cycle: clr_i > load_i > edge.
  - clr: count=0, wrap=0; a simultaneous edge is dropped.
  - load: count=load_val; wrap unchanged; edge dropped.
  - edge, up: count<max -> +1. count==max: sat=1 -> hold max; sat=0 -> 0 and wrap<=1.
  - edge, down: count>0 -> -1. count==0: sat=1 -> hold 0; sat=0 -> max and wrap<=1.
  - no event: hold.
- History register updates every cycle regardless of clr/load, so an edge consumed by clr/load does not re-fire next cycle.
- Arithmetic is exactly COUNT_WIDTH bits; no carry out is exposed other than wrap_o.
- dir_i and sat_i matter only in a cycle with an accepted edge.
- Channels are fully independent; no cross-channel interaction.
- Reset asserted mid-operation clears everything immediately, regardless of clock.

Optional Feature:
Macro EDGE_COUNTER_SYNC_EN.
- Defined: each next_i bit passes through a 2-flop synchronizer (reset 0) before edge detect. Edge-to-count latency becomes 3 clocks; the "high at reset release" edge is counted 2 cycles later.
- Undefined: next_i is used directly, with 1-clock latency; next_i must then be synchronous to clk_i.

Decomposition:
- Shared package/include edge_counter_pkg holds:
  - default width/channel constants
  - direction encodings DIR_UP=1, DIR_DOWN=0
  - mode encodings MODE_WRAP=0, MODE_SAT=1
- Sub-module edge_counter_ch implements one channel: optional sync, edge detect, counter, flags.
- The top level is a generate loop over NUM_CH that slices the packed buses.

Test Plan:
1. Reset, then pulse next_i[0] 5 times (1 cycle high, 1 low), dir=1 -> ch0 count=5; other channels 0; zero_o=4'b1110.
2. Hold next_i[1] high 10 cycles -> count=1 only. Drive high before reset release -> counted once after release.
3. ch2 load 8'hFE, sat=0, up, 3 edges -> FF (max_o[2]=1), 00 (wrap_o[2]=1), 01. Repeat with sat=1 -> FF, FF, FF and wrap_o[2]=0.
4. ch3 count=0, dir=0, sat=0, one edge -> FF, wrap_o[3]=1. Then clr_i -> 0, wrap_o[3]=0.
5. Same cycle clr_i=1, load_i=1, edge on ch0 -> count=0. load_i plus edge -> count=load_val. Next cycle, next_i still high -> no extra count.
6. Assert rstn_i low mid-count, off-clock -> all outputs at reset values immediately. With EDGE_COUNTER_SYNC_EN defined, the first count appears 3 clocks after the edge.

Source files
------------

// File: rtl/edge_counter_pkg.sv
// Shared constants and encodings for the edge counter bank.
// Optional build macro EDGE_COUNTER_SYNC_EN adds a 2-flop input synchronizer per channel.
package edge_counter_pkg;

  localparam int unsigned DEF_NUM_CH      = 4;
  localparam int unsigned DEF_COUNT_WIDTH = 8;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

endpackage

// File: rtl/edge_counter_ch.sv
// One counter channel: optional input sync, rising-edge detect, up/down counter
// with clear/load priority, saturate-or-wrap limits, terminal and sticky wrap flags.
// Optional build macro EDGE_COUNTER_SYNC_EN inserts a 2-flop synchronizer on next_i.
module edge_counter_ch
  import edge_counter_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   next_i,
  input  logic                   dir_i,
  input  logic                   clr_i,
  input  logic                   load_i,
  input  logic [COUNT_WIDTH-1:0] load_val_i,
  input  logic                   sat_i,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic                   max_o,
  output logic                   zero_o,
  output logic                   wrap_o
);

  logic                   next_s;
  logic                   hist_q;
  logic                   edge_s;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   wrap_q, wrap_d;

`ifdef EDGE_COUNTER_SYNC_EN
  logic [1:0] sync_q;

  // Two-stage synchronizer for an asynchronous event source.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) sync_q <= '0;
    else         sync_q <= {sync_q[0], next_i};
  end

  assign next_s = sync_q[1];
`else
  assign next_s = next_i;
`endif

  // Edge history tracks the input every cycle, even when clr/load swallow the edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) hist_q <= 1'b0;
    else         hist_q <= next_s;
  end

  assign edge_s = next_s & ~hist_q;

  // Next count: clear beats load beats edge; limits either saturate or wrap.
  always_comb begin
    count_d = count_q;
    wrap_d  = wrap_q;
    if (clr_i) begin
      count_d = '0;
      wrap_d  = 1'b0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (edge_s) begin
      if (dir_e'(dir_i) == DIR_UP) begin
        if (count_q != '1) begin
          count_d = count_q + COUNT_WIDTH'(1);
        end else if (mode_e'(sat_i) == MODE_WRAP) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        if (count_q != '0) begin
          count_d = count_q - COUNT_WIDTH'(1);
        end else if (mode_e'(sat_i) == MODE_WRAP) begin
          count_d = '1;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  // Count and sticky wrap registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_o = count_q;
  assign max_o   = (count_q == '1);
  assign zero_o  = (count_q == '0);
  assign wrap_o  = wrap_q;

endmodule

// File: rtl/edge_counter_bank.sv
// Multi-channel rising-edge event counter bank; one edge_counter_ch per channel,
// packed buses sliced COUNT_WIDTH bits per channel.
// Optional build macro EDGE_COUNTER_SYNC_EN (see edge_counter_ch).
module edge_counter_bank
  import edge_counter_pkg::*;
#(
  parameter int unsigned NUM_CH      = DEF_NUM_CH,
  parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [NUM_CH-1:0]             next_i,
  input  logic [NUM_CH-1:0]             dir_i,
  input  logic [NUM_CH-1:0]             clr_i,
  input  logic [NUM_CH-1:0]             load_i,
  input  logic [NUM_CH*COUNT_WIDTH-1:0] load_val_i,
  input  logic [NUM_CH-1:0]             sat_i,
  output logic [NUM_CH*COUNT_WIDTH-1:0] count_o,
  output logic [NUM_CH-1:0]             max_o,
  output logic [NUM_CH-1:0]             zero_o,
  output logic [NUM_CH-1:0]             wrap_o
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    edge_counter_ch #(
      .COUNT_WIDTH(COUNT_WIDTH)
    ) u_ch (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .next_i     (next_i[c]),
      .dir_i      (dir_i[c]),
      .clr_i      (clr_i[c]),
      .load_i     (load_i[c]),
      .load_val_i (load_val_i[c*COUNT_WIDTH +: COUNT_WIDTH]),
      .sat_i      (sat_i[c]),
      .count_o    (count_o[c*COUNT_WIDTH +: COUNT_WIDTH]),
      .max_o      (max_o[c]),
      .zero_o     (zero_o[c]),
      .wrap_o     (wrap_o[c])
    );
  end

endmodule

// File: tb/tb_edge_counter_bank.sv
// Self-checking bench for edge_counter_bank: directed steps plus a random phase,
// compared every cycle against an arithmetic reference model.
module tb_edge_counter_bank;

  localparam int NUM_CH = 4;
  localparam int W      = 8;
  localparam int MAXV   = (1 << W) - 1;

  logic                   clk_i = 1'b0;
  logic                   rstn_i = 1'b1;
  logic [NUM_CH-1:0]      next_i = '0;
  logic [NUM_CH-1:0]      dir_i = '1;
  logic [NUM_CH-1:0]      clr_i = '0;
  logic [NUM_CH-1:0]      load_i = '0;
  logic [NUM_CH*W-1:0]    load_val_i = '0;
  logic [NUM_CH-1:0]      sat_i = '0;
  logic [NUM_CH*W-1:0]    count_o;
  logic [NUM_CH-1:0]      max_o;
  logic [NUM_CH-1:0]      zero_o;
  logic [NUM_CH-1:0]      wrap_o;

  edge_counter_bank #(
    .NUM_CH     (NUM_CH),
    .COUNT_WIDTH(W)
  ) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .next_i     (next_i),
    .dir_i      (dir_i),
    .clr_i      (clr_i),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .sat_i      (sat_i),
    .count_o    (count_o),
    .max_o      (max_o),
    .zero_o     (zero_o),
    .wrap_o     (wrap_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: plain integers per channel.
  int cnt  [NUM_CH];
  bit wrp  [NUM_CH];
  bit prev [NUM_CH];
  bit s0   [NUM_CH];
  bit s1   [NUM_CH];

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      cnt[c] = 0; wrp[c] = 0; prev[c] = 0; s0[c] = 0; s1[c] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int c = 0; c < NUM_CH; c++) begin
      bit seen;
      bit ev;
      int n;
`ifdef EDGE_COUNTER_SYNC_EN
      seen = s1[c];
`else
      seen = next_i[c];
`endif
      ev = seen && !prev[c];
      s1[c] = s0[c];
      s0[c] = next_i[c];
      prev[c] = seen;
      if (clr_i[c]) begin
        cnt[c] = 0;
        wrp[c] = 0;
      end else if (load_i[c]) begin
        cnt[c] = int'(load_val_i[c*W +: W]);
      end else if (ev) begin
        n = cnt[c] + (dir_i[c] ? 1 : -1);
        if (n < 0 || n > MAXV) begin
          if (sat_i[c]) n = (n < 0) ? 0 : MAXV;
          else begin
            n = (n + MAXV + 1) % (MAXV + 1);
            wrp[c] = 1;
          end
        end
        cnt[c] = n;
      end
    end
  endfunction

  task automatic check(input string tag);
    logic [NUM_CH*W-1:0] ec;
    logic [NUM_CH-1:0]   em, ez, ew;
    for (int c = 0; c < NUM_CH; c++) begin
      ec[c*W +: W] = W'(cnt[c]);
      em[c] = (cnt[c] == MAXV);
      ez[c] = (cnt[c] == 0);
      ew[c] = wrp[c];
    end
    n_cmp++;
    assert (count_o === ec) else begin
      n_err++; $error("FAIL %s count_o observed %h expected %h", tag, count_o, ec);
    end
    n_cmp++;
    assert (max_o === em) else begin
      n_err++; $error("FAIL %s max_o observed %b expected %b", tag, max_o, em);
    end
    n_cmp++;
    assert (zero_o === ez) else begin
      n_err++; $error("FAIL %s zero_o observed %b expected %b", tag, zero_o, ez);
    end
    n_cmp++;
    assert (wrap_o === ew) else begin
      n_err++; $error("FAIL %s wrap_o observed %b expected %b", tag, wrap_o, ew);
    end
  endtask

  // One clock: model sees the same inputs the DUT samples, then compare off-edge.
  task automatic tick(input string tag);
    @(posedge clk_i);
    model_step();
    #1;
    check(tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic pulse(input int c, input string tag);
    next_i[c] = 1'b1;
    tick(tag);
    next_i[c] = 1'b0;
    tick(tag);
  endtask

  task automatic check_const(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++; $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with ch1 already high before release.
    #1 rstn_i = 1'b0;
    next_i = 4'b0010;
    model_reset();
    #2 check("reset");
    @(negedge clk_i);
    rstn_i = 1'b1;

    // Pulse ch0 five times, ch1 held high throughout.
    for (int i = 0; i < 5; i++) pulse(0, "ch0_pulse");
    ticks(3, "settle1");
    check_const("ch0_five", 32'(count_o[0 +: W]), 32'd5);
    check_const("ch1_once", 32'(count_o[W +: W]), 32'd1);
    check_const("zero_bits", 32'(zero_o), 32'b1100);
    next_i[1] = 1'b0;

    // ch2 wrap mode from FE.
    dir_i = '1; sat_i = '0;
    load_i[2] = 1'b1; load_val_i[2*W +: W] = 8'hFE;
    tick("ch2_load");
    load_i[2] = 1'b0;
    for (int i = 0; i < 3; i++) pulse(2, "ch2_wrap");
    ticks(3, "settle2");
    check_const("ch2_wrap_cnt", 32'(count_o[2*W +: W]), 32'h01);
    check_const("ch2_wrap_flag", 32'(wrap_o[2]), 32'd1);

    // ch2 saturate mode from FE after clear.
    clr_i[2] = 1'b1; tick("ch2_clr"); clr_i[2] = 1'b0;
    sat_i[2] = 1'b1;
    load_i[2] = 1'b1; tick("ch2_load2"); load_i[2] = 1'b0;
    for (int i = 0; i < 3; i++) pulse(2, "ch2_sat");
    ticks(3, "settle3");
    check_const("ch2_sat_cnt", 32'(count_o[2*W +: W]), 32'hFF);
    check_const("ch2_sat_max", 32'(max_o[2]), 32'd1);
    check_const("ch2_sat_nowrap", 32'(wrap_o[2]), 32'd0);

    // ch3 down past zero, then clear.
    dir_i[3] = 1'b0; sat_i[3] = 1'b0;
    pulse(3, "ch3_down");
    ticks(3, "settle4");
    check_const("ch3_under_cnt", 32'(count_o[3*W +: W]), 32'hFF);
    check_const("ch3_under_wrap", 32'(wrap_o[3]), 32'd1);
    clr_i[3] = 1'b1; tick("ch3_clr"); clr_i[3] = 1'b0;
    check_const("ch3_clr_cnt", 32'(count_o[3*W +: W]), 32'h00);
    check_const("ch3_clr_wrap", 32'(wrap_o[3]), 32'd0);

    // ch0 priority: clr+load+edge, then load+edge, level held.
    dir_i[0] = 1'b1;
    load_val_i[0 +: W] = 8'h5A;
    next_i[0] = 1'b1; clr_i[0] = 1'b1; load_i[0] = 1'b1;
    tick("prio_clr");
    clr_i[0] = 1'b0; load_i[0] = 1'b0;
    tick("prio_hold");
    next_i[0] = 1'b0; tick("prio_low");
    load_val_i[0 +: W] = 8'h33;
    next_i[0] = 1'b1; load_i[0] = 1'b1;
    tick("prio_load");
    load_i[0] = 1'b0;
    ticks(4, "prio_level");
    next_i[0] = 1'b0;
    ticks(3, "settle5");

    // Random phase.
    for (int i = 0; i < 400; i++) begin
      next_i = NUM_CH'($urandom);
      dir_i  = NUM_CH'($urandom);
      sat_i  = NUM_CH'($urandom);
      for (int c = 0; c < NUM_CH; c++) begin
        clr_i[c]  = ($urandom_range(0, 31) == 0);
        load_i[c] = ($urandom_range(0, 15) == 0);
        load_val_i[c*W +: W] = ($urandom_range(0, 3) == 0) ? 8'hFF :
                               ($urandom_range(0, 2) == 0) ? 8'h00 : W'($urandom);
      end
      tick("random");
    end
    clr_i = '0; load_i = '0;

    // Asynchronous reset between clock edges.
    @(posedge clk_i);
    model_step();
    #2 rstn_i = 1'b0;
    model_reset();
    #1 check("async_reset");
    next_i = '1;
    @(negedge clk_i);
    rstn_i = 1'b1;
    ticks(6, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
